// File: rtl/bnn_pkg.sv
// Shared constants and types for the MNIST BNN layer-1 convolution path.
package bnn_pkg;

  localparam int IMG_W   = 28;
  localparam int K       = 3;
  localparam int N_FILT  = 8;
  localparam int MAX_OUT = 2;

  localparam int OUT_W   = IMG_W - K + 1;           // 26 window positions per axis
  localparam int NUM_WIN = OUT_W * OUT_W * N_FILT;  // 5408 result bits per layer
  localparam int ADDR_W  = $clog2(NUM_WIN);         // 13
  localparam int ROW_W   = $clog2(OUT_W);           // 5
  localparam int FILT_W  = $clog2(N_FILT);          // 3

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } conv_state_e;

endpackage

// File: rtl/conv1_scheduler_if.sv
// Coordinate-issue and result-return bus between the conv1 scheduler and the
// XNOR-popcount datapath / layer-1 feature buffer.
interface conv1_scheduler_if;
  import bnn_pkg::*;

  logic [ROW_W-1:0]  win_row;
  logic [ROW_W-1:0]  win_col;
  logic [FILT_W-1:0] filt_sel;
  logic              win_valid;
  logic              win_ready;
  logic              res_valid;
  logic              res_bit;
  logic              out_we;
  logic [ADDR_W-1:0] out_addr;
  logic              out_bit;

  // Scheduler side.
  modport master (
    output win_row, win_col, filt_sel, win_valid, out_we, out_addr, out_bit,
    input  win_ready, res_valid, res_bit
  );

  // Datapath / feature-buffer side.
  modport slave (
    input  win_row, win_col, filt_sel, win_valid, out_we, out_addr, out_bit,
    output win_ready, res_valid, res_bit
  );

endinterface

// File: rtl/wrap_counter.sv
// Modulo-MAX counter; wrap flags the increment that returns it to zero so
// counters can be chained (filter -> column -> row).
module wrap_counter #(
  parameter  int MAX = 8,
  localparam int W   = (MAX > 1) ? $clog2(MAX) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] value,
  output logic         wrap
);

  assign wrap = inc && (value == W'(MAX - 1));

  // Count up on inc, returning to zero after MAX-1; clear restarts a layer.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registered state uses non-blocking assignment so every flop
    // samples pre-edge values, independent of block evaluation order.
    if (!rst_n)      value <= '0;
    else if (clear)  value <= '0;
    else if (inc)    value <= wrap ? '0 : value + W'(1);
  end

endmodule

// File: rtl/conv1_scheduler.sv
// Layer-1 convolution sequencer: walks every (row, col, filter) tuple, issues
// it to the datapath under a credit limit, and writes the in-order result bits
// to consecutive feature-buffer addresses.
module conv1_scheduler #(
  parameter int IMG_W   = bnn_pkg::IMG_W,
  parameter int K       = bnn_pkg::K,
  parameter int N_FILT  = bnn_pkg::N_FILT,
  parameter int MAX_OUT = bnn_pkg::MAX_OUT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  conv1_scheduler_if.master        bus,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int OUT_W   = IMG_W - K + 1;
  localparam int NUM_WIN = OUT_W * OUT_W * N_FILT;
  localparam int ADDR_W  = bnn_pkg::ADDR_W;
  localparam int CNT_W   = $clog2(MAX_OUT + 1);

  bnn_pkg::conv_state_e state, state_nxt;

  logic              handshake;
  logic              res_ok;
  logic              spurious;
  logic              accept_start;
  logic              f_wrap, c_wrap, r_wrap;
  logic [CNT_W-1:0]  outst, outst_nxt;
  logic [ADDR_W-1:0] res_cnt, res_cnt_nxt;

  assign accept_start = (state == bnn_pkg::IDLE) && start;
  assign handshake    = bus.win_valid && bus.win_ready;
  assign res_ok       = bus.res_valid && (outst != '0);
  assign spurious     = bus.res_valid && (outst == '0);

  // A handshake and a returned result in the same cycle cancel out.
  assign outst_nxt   = outst + CNT_W'(handshake) - CNT_W'(res_ok);
  assign res_cnt_nxt = res_cnt + ADDR_W'(res_ok);

  // Filter is the innermost loop, then column, then row.
  wrap_counter #(.MAX(N_FILT)) u_filt (
    .clk(clk), .rst_n(rst_n), .inc(handshake), .clear(accept_start),
    .value(bus.filt_sel), .wrap(f_wrap)
  );
  wrap_counter #(.MAX(OUT_W)) u_col (
    .clk(clk), .rst_n(rst_n), .inc(f_wrap), .clear(accept_start),
    .value(bus.win_col), .wrap(c_wrap)
  );
  wrap_counter #(.MAX(OUT_W)) u_row (
    .clk(clk), .rst_n(rst_n), .inc(c_wrap), .clear(accept_start),
    .value(bus.win_row), .wrap(r_wrap)
  );

  assign bus.win_valid = (state == bnn_pkg::ISSUE) && (outst < CNT_W'(MAX_OUT));
  assign bus.out_we    = res_ok;
  assign bus.out_addr  = res_cnt;
  assign bus.out_bit   = res_ok && bus.res_bit;
  assign busy          = (state == bnn_pkg::ISSUE) || (state == bnn_pkg::DRAIN);
  assign done          = (state == bnn_pkg::DONE);

  // Next-state logic: leave DRAIN as the final result is written, so done
  // rises the cycle after the last write.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven,
    // so no latch is inferred for state_nxt.
    state_nxt = state;
    unique case (state)
      bnn_pkg::IDLE:  if (start) state_nxt = bnn_pkg::ISSUE;
      bnn_pkg::ISSUE: if (handshake && r_wrap) state_nxt = bnn_pkg::DRAIN;
      bnn_pkg::DRAIN: if ((outst_nxt == '0) && (res_cnt_nxt == ADDR_W'(NUM_WIN)))
                        state_nxt = bnn_pkg::DONE;
      bnn_pkg::DONE:  state_nxt = bnn_pkg::IDLE;
      default:        state_nxt = bnn_pkg::IDLE;
    endcase
  end

  // State, credit, result-count and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= bnn_pkg::IDLE;
      outst   <= '0;
      res_cnt <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      outst <= outst_nxt;
      res_cnt <= accept_start ? '0 : res_cnt_nxt;
      err     <= (accept_start ? 1'b0 : err) | spurious;
    end
  end

endmodule

// File: tb/tb_conv1_scheduler.sv
// Self-checking bench for conv1_scheduler: a latency-configurable datapath
// model returns random result bits in order, and a tuple-index reference
// decodes the expected (row, col, filter) sequence arithmetically.
module tb_conv1_scheduler;
  import bnn_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy, done, err;

  int n_checks = 0;
  int n_errors = 0;

  conv1_scheduler_if bus();

  conv1_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus.master),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    logic [63:0] all_out;
    rst_n = 1'b0; start = 1'b0;
    bus.win_ready = 1'b0; bus.res_valid = 1'b0; bus.res_bit = 1'b0;
    repeat (3) @(negedge clk);
    all_out = 64'({bus.win_row, bus.win_col, bus.filt_sel, bus.win_valid, bus.out_we,
                   bus.out_addr, bus.out_bit, busy, done, err});
    n_checks++;
    if (all_out !== 64'd0) begin
      n_errors++; $display("FAIL reset_outputs got=%h want=0", all_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
    all_out = 64'({bus.win_row, bus.win_col, bus.filt_sel, bus.win_valid, bus.out_we,
                   bus.out_addr, bus.out_bit, busy, done, err});
    n_checks++;
    if (all_out !== 64'd0) begin
      n_errors++; $display("FAIL post_reset_idle got=%h want=0", all_out);
    end
  endtask

  // A result with nothing outstanding must flag err and not write.
  task automatic test_spurious(input string name);
    @(negedge clk);
    bus.res_valid = 1'b1; bus.res_bit = 1'b1;
    #1;
    n_checks++;
    if (bus.out_we !== 1'b0) begin
      n_errors++; $display("FAIL %s spurious_we got=%b want=0", name, bus.out_we);
    end
    @(negedge clk);
    bus.res_valid = 1'b0; bus.res_bit = 1'b0;
    #1;
    n_checks++;
    if (err !== 1'b1) begin
      n_errors++; $display("FAIL %s spurious_err got=%b want=1", name, err);
    end
    n_checks++;
    if (bus.out_addr !== '0) begin
      n_errors++; $display("FAIL %s spurious_addr got=%0d want=0", name, bus.out_addr);
    end
  endtask

  // Run one layer. lat = datapath latency, rdy_pct = win_ready probability,
  // abort_at >= 0 pulses rst_n once that many tuples have been accepted.
  task automatic run_layer(input string name, input int lat, input int rdy_pct,
                           input int abort_at);
    int issued = 0, written = 0, dones = 0, cyc = 0;
    int done_cyc = -1, last_we_cyc = -1, same_cnt = 0, credit_stalls = 0;
    int outst_m, er, ec, ef;
    bit finished = 0, prev_stall = 0, rv, hs, b;
    logic [4:0] pr, pc;
    logic [2:0] pf;
    logic [63:0] all_out;
    int due_q[$];
    bit bit_q[$];

    @(negedge clk);
    start = 1'b1; bus.res_valid = 1'b0; bus.win_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;

    while (!finished) begin
      rv = (due_q.size() > 0) && (due_q[0] <= cyc);
      bus.res_valid = rv;
      bus.res_bit   = rv ? bit_q[0] : 1'b0;
      bus.win_ready = ($urandom_range(99) < rdy_pct);
      #1;
      outst_m = issued - written;
      hs = bus.win_valid && bus.win_ready;

      if (cyc == 0) begin
        n_checks++;
        if ({bus.win_valid, busy, err} !== 3'b110) begin
          n_errors++; $display("FAIL %s first_cycle valid/busy/err got=%b want=110",
                               name, {bus.win_valid, busy, err});
        end
      end

      if (prev_stall) begin
        n_checks++;
        if (!bus.win_valid || {bus.win_row, bus.win_col, bus.filt_sel} !== {pr, pc, pf}) begin
          n_errors++; $display("FAIL %s hold got=%0d,%0d,%0d v=%b want=%0d,%0d,%0d v=1", name,
                               bus.win_row, bus.win_col, bus.filt_sel, bus.win_valid, pr, pc, pf);
        end
      end

      if (outst_m >= MAX_OUT) begin
        credit_stalls++;
        n_checks++;
        if (bus.win_valid !== 1'b0) begin
          n_errors++; $display("FAIL %s credit outst=%0d valid got=%b want=0",
                               name, outst_m, bus.win_valid);
        end
      end

      if (lat == 1 && rdy_pct == 100 && issued < NUM_WIN) begin
        n_checks++;
        if (bus.win_valid !== 1'b1) begin
          n_errors++; $display("FAIL %s bubble cyc=%0d valid got=%b want=1",
                               name, cyc, bus.win_valid);
        end
      end

      if (hs) begin
        er = issued / (OUT_W * N_FILT);
        ec = (issued / N_FILT) % OUT_W;
        ef = issued % N_FILT;
        n_checks++;
        if (issued >= NUM_WIN ||
            {bus.win_row, bus.win_col, bus.filt_sel} !== {5'(er), 5'(ec), 3'(ef)}) begin
          n_errors++; $display("FAIL %s tuple#%0d got=%0d,%0d,%0d want=%0d,%0d,%0d", name,
                               issued, bus.win_row, bus.win_col, bus.filt_sel, er, ec, ef);
        end
        if (rv && outst_m == 1) same_cnt++;
        issued++;
        b = 1'($urandom_range(1));
        due_q.push_back(cyc + lat);
        bit_q.push_back(b);
      end

      n_checks++;
      if (bus.out_we !== rv) begin
        n_errors++; $display("FAIL %s out_we cyc=%0d got=%b want=%b", name, cyc, bus.out_we, rv);
      end
      if (rv) begin
        n_checks++;
        if (bus.out_addr !== ADDR_W'(written) || bus.out_bit !== bit_q[0]) begin
          n_errors++; $display("FAIL %s write addr/bit got=%0d/%b want=%0d/%b", name,
                               bus.out_addr, bus.out_bit, written, bit_q[0]);
        end
        written++;
        last_we_cyc = cyc;
        void'(due_q.pop_front());
        void'(bit_q.pop_front());
      end

      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
        n_checks++;
        if (busy !== 1'b0 || cyc != last_we_cyc + 1 || written != NUM_WIN) begin
          n_errors++; $display("FAIL %s done_timing busy=%b cyc=%0d last_we=%0d written=%0d want busy=0 cyc=last_we+1 written=%0d",
                               name, busy, cyc, last_we_cyc, written, NUM_WIN);
        end
      end

      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        n_checks++;
        if ({done, busy, bus.win_valid} !== 3'b000) begin
          n_errors++; $display("FAIL %s after_done done/busy/valid got=%b want=000",
                               name, {done, busy, bus.win_valid});
        end
        finished = 1;
      end

      if (abort_at >= 0 && issued == abort_at) begin
        #1 rst_n = 1'b0;
        #1;
        all_out = 64'({bus.win_row, bus.win_col, bus.filt_sel, bus.win_valid, bus.out_we,
                       bus.out_addr, bus.out_bit, busy, done, err});
        n_checks++;
        if (all_out !== 64'd0) begin
          n_errors++; $display("FAIL %s async_reset got=%h want=0", name, all_out);
        end
        @(negedge clk);
        rst_n = 1'b1; bus.win_ready = 1'b0;
        bus.res_valid = 1'b1; bus.res_bit = 1'b1;   // late result from the aborted layer
        #1;
        n_checks++;
        if (bus.out_we !== 1'b0 || bus.out_addr !== '0) begin
          n_errors++; $display("FAIL %s late_result we/addr got=%b/%0d want=0/0",
                               name, bus.out_we, bus.out_addr);
        end
        @(negedge clk);
        bus.res_valid = 1'b0; bus.res_bit = 1'b0;
        #1;
        n_checks++;
        if (err !== 1'b1) begin
          n_errors++; $display("FAIL %s late_result_err got=%b want=1", name, err);
        end
        return;
      end

      prev_stall = bus.win_valid && !bus.win_ready;
      pr = bus.win_row; pc = bus.win_col; pf = bus.filt_sel;

      if (!finished && cyc > 40000) begin
        n_checks++; n_errors++;
        $display("FAIL %s timeout issued=%0d written=%0d want %0d", name, issued, written, NUM_WIN);
        finished = 1;
      end
      @(negedge clk);
      cyc++;
    end
    bus.res_valid = 1'b0; bus.win_ready = 1'b0;

    n_checks++;
    if (issued != NUM_WIN || written != NUM_WIN) begin
      n_errors++; $display("FAIL %s totals issued=%0d written=%0d want %0d",
                           name, issued, written, NUM_WIN);
    end
    n_checks++;
    if (dones != 1) begin
      n_errors++; $display("FAIL %s done_pulses got=%0d want=1", name, dones);
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_errors++; $display("FAIL %s err_end got=%b want=0", name, err);
    end
    if (lat == 1 && rdy_pct == 100) begin
      n_checks++;
      if (same_cnt == 0) begin
        n_errors++; $display("FAIL %s same_cycle_events got=0 want>0", name);
      end
    end
    if (lat >= 3) begin
      n_checks++;
      if (credit_stalls == 0) begin
        n_errors++; $display("FAIL %s credit_stall_cycles got=0 want>0", name);
      end
    end
  endtask

  initial begin
    test_reset();
    test_spurious("idle");
    run_layer("test_ideal", 1, 100, -1);
    run_layer("test_backpressure", 2, 60, -1);
    run_layer("test_latency4", 4, 100, -1);
    run_layer("test_abort", 1, 100, 1000);
    run_layer("test_restart", 1, 85, -1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/conv1_scheduler.md
# conv1_scheduler

Sequencer for the first binarized convolution layer of the MNIST BNN. On a start pulse from the top FSM (load state finished, layer‑1 state entered) it walks every valid 3×3 window of the 28×28 pixel register bank against each of the 8 loaded filters. It issues window/filter coordinates to the XNOR‑popcount datapath with a credit‑limited valid/ready handshake, and collects the in‑order result bits into sequential output addresses. It raises the `layer_1_done` pulse consumed by the FSM.

## Interface
Parameters:
- `IMG_W`, default 28: input image side, in pixels.
- `K`, default 3: kernel side.
- `N_FILT`, default 8: number of filters.
- `MAX_OUT`, default 2: maximum issued‑but‑unreturned windows (datapath pipeline depth).

Ports:
- `clk`, in, 1: clock. One clock; all state on its rising edge.
- `rst_n`, in, 1: reset, asynchronous, active‑low.
- `start`, in, 1: begin layer; sampled only in IDLE.
- `win_row`, out, 5: top row of the current window, 0..OUT_W‑1.
- `win_col`, out, 5: left column of the current window, 0..OUT_W‑1.
- `filt_sel`, out, 3: filter index, 0..N_FILT‑1.
- `win_valid`, out, 1: coordinates valid.
- `win_ready`, in, 1: datapath accepts coordinates.
- `res_valid`, in, 1: datapath returns one result bit, in issue order.
- `res_bit`, in, 1: binarized result.
- `out_we`, out, 1: write strobe to the layer‑1 feature buffer.
- `out_addr`, out, 13: feature address, 0..NUM_WIN‑1.
- `out_bit`, out, 1: data bit for the write.
- `busy`, out, 1: high in ISSUE and DRAIN.
- `done`, out, 1: one‑cycle pulse; drives the FSM's `layer_1_done`.
- `err`, out, 1: sticky protocol error flag.

## Operation
- Derived values: OUT_W = IMG_W−K+1 = 26; NUM_WIN = OUT_W²·N_FILT = 5408.
- Iteration order is filter innermost, then column, then row. Order is (r,c,f) = (0,0,0),(0,0,1)…(0,0,7),(0,1,0)…(25,25,7).
- States:
  - IDLE → ISSUE on `start`.
  - ISSUE → DRAIN on the handshake of the last tuple (25,25,7).
  - DRAIN → DONE when the outstanding count is 0 and the result count equals NUM_WIN.
  - DONE → IDLE unconditionally.
- `win_valid` = (state==ISSUE) && (outstanding < MAX_OUT).
- Coordinates hold stable while `win_valid` && !`win_ready`.
- Handshake = `win_valid` && `win_ready`.
  - Advances the counters: f wraps 7→0 with c+1; c wraps 25→0 with r+1.
  - Increments outstanding.
- Each `res_valid`:
  - Decrements outstanding.
  - Drives `out_we`=1, `out_bit`=`res_bit`, `out_addr`=result count. Write is combinational from `res_valid`, same cycle.
  - Increments the result count after the write.
- Handshake and `res_valid` in the same cycle leave outstanding unchanged.
- `res_valid` with outstanding==0 sets `err`, and is ignored (no write, no counter change).
- `start` outside IDLE is ignored; there is no restart mid‑layer.
- `err` clears only on reset or on an accepted `start`.
- `out_addr` = (r·OUT_W + c)·N_FILT + f of the returned result. This is identical to the sequential result count, because results return in order.

## Timing
- Reset values: state IDLE; r, c, f, outstanding and result count = 0. All outputs 0: `win_row`, `win_col`, `filt_sel`, `win_valid`, `out_we`, `out_addr`, `out_bit`, `busy`, `done`, `err`.
- Reset asserted mid‑layer aborts immediately to the reset values. Results arriving after reset are not written, since outstanding==0, and they set `err`.
- Start to first issue: `start` high in cycle 0 gives `win_valid`=1 with (0,0,0) in cycle 1.
- Throughput is one tuple per cycle while `win_ready`=1 and credits are available. With MAX_OUT=2 and a 1‑cycle datapath, no bubbles occur.
- `done` asserts in the cycle after DRAIN sees the final result written. That is one cycle after the last `out_we`.
- `busy` falls in the same cycle `done` rises.
- Minimum layer time with an ideal datapath: 5408 + latency + 2 cycles.

## Structure
- Shared package `bnn_pkg` holds:
  - Constants IMG_W, K, N_FILT, OUT_W, NUM_WIN, MAX_OUT.
  - Address width ADDR_W = $clog2(NUM_WIN) = 13.
  - State enum `conv_state_e` {IDLE, ISSUE, DRAIN, DONE}.
- One sub‑module, `wrap_counter` (parameter MAX; ports inc, clear, value, wrap).
  - Instantiated three times for f, c and r, chained through `wrap`.
- Outstanding and result counters stay inline.

## Test plan
- Reset, then `start` with `win_ready`=1 and 1‑cycle result return:
  - exactly 5408 `out_we` pulses, addresses 0..5407 contiguous;
  - the first three tuples are (0,0,0),(0,0,1),(0,0,2);
  - the last tuple is (25,25,7);
  - one `done` pulse; `err`=0.
- Random `win_ready` backpressure: coordinates are held stable while stalled, and there are no skipped or duplicated tuples (scoreboard against a reference iterator).
- Datapath latency 4 with MAX_OUT=2: `win_valid` drops while outstanding==2, and is never above 2 outstanding.
- Same‑cycle handshake and `res_valid` at outstanding==1: outstanding stays 1 and the write lands at the correct address.
- Spurious `res_valid` in IDLE: `err`=1, no `out_we`. A following `start` clears `err`.
- `rst_n` pulsed low at tuple 1000: all outputs return to 0 asynchronously. A new `start` restarts at (0,0,0), address 0.
